// File: rtl/alu_pkg.sv
// Shared types for the ALU operand loader: FSM state encoding and opcode width.
package alu_pkg;

  localparam int MODE_W = 4;

  typedef enum logic [1:0] {
    LOAD_A  = 2'd0,
    LOAD_B  = 2'd1,
    LOAD_OP = 2'd2,
    EXEC    = 2'd3
  } loader_state_t;

endpackage

// File: rtl/btn_debounce.sv
// Raw push button -> 2-flop sync -> stability counter -> registered one-cycle rise pulse.
module btn_debounce #(
  parameter int DB_CYCLES = 500000
) (
  input  logic clk,
  input  logic rst_n,
  input  logic btn,
  output logic press
);

  localparam int CW = $clog2(DB_CYCLES + 1);
  localparam logic [CW-1:0] LAST = CW'(DB_CYCLES - 1);

  logic [1:0]    sync;
  logic [CW-1:0] cnt;
  logic          db;
  logic          db_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync  <= '0;
      cnt   <= '0;
      db    <= 1'b0;
      db_q  <= 1'b0;
      press <= 1'b0;
    end else begin
      sync  <= {sync[0], btn};
      db_q  <= db;
      press <= db & ~db_q;
      // Any cycle where the synchronized level agrees with db restarts the count.
      if (sync[1] == db)
        cnt <= '0;
      else if (cnt == LAST) begin
        cnt <= '0;
        db  <= ~db;
      end else
        cnt <= cnt + 1'b1;
    end
  end

endmodule

// File: rtl/alu_operand_loader.sv
// Steps operand A, operand B and opcode from switches into ALU registers on debounced presses.
module alu_operand_loader
  import alu_pkg::*;
#(
  parameter int N         = 4,
  parameter int DB_CYCLES = 500000
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [N-1:0]      sw,
  input  logic [MODE_W-1:0] sw_mode,
  input  logic              btn_next,
  input  logic              btn_clr,
  output logic [N-1:0]      in1,
  output logic [N-1:0]      in2,
  output logic [MODE_W-1:0] mode,
  output logic              valid,
  output logic [1:0]        state_o
);

  loader_state_t state;
  logic [1:0]    press;  // [0]=next, [1]=clr

  btn_debounce #(.DB_CYCLES(DB_CYCLES)) u_db [1:0] (
    .clk   (clk),
    .rst_n (rst_n),
    .btn   ({btn_clr, btn_next}),
    .press (press)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= LOAD_A;
      in1   <= '0;
      in2   <= '0;
      mode  <= '0;
    end else if (press[1]) begin
      // clr wins over a coincident next
      state <= LOAD_A;
      in1   <= '0;
      in2   <= '0;
      mode  <= '0;
    end else if (press[0]) begin
      case (state)
        LOAD_A:  begin in1  <= sw;      state <= LOAD_B;  end
        LOAD_B:  begin in2  <= sw;      state <= LOAD_OP; end
        LOAD_OP: begin mode <= sw_mode; state <= EXEC;    end
        default: state <= LOAD_A;
      endcase
    end
  end

  assign valid   = (state == EXEC);
  assign state_o = state;

endmodule

// File: tb/tb_alu_operand_loader.sv
// Randomized scoreboard bench for alu_operand_loader with N=4, DB_CYCLES=4.
module tb_alu_operand_loader;

  localparam int N   = 4;
  localparam int DB  = 4;
  localparam int LAT = DB + 4;  // stimulus negedge -> observed at negedge after edge t+7

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic [N-1:0] sw = '0;
  logic [3:0]   sw_mode = '0;
  logic         btn_next = 1'b0;
  logic         btn_clr = 1'b0;
  logic [N-1:0] in1, in2;
  logic [3:0]   mode;
  logic         valid;
  logic [1:0]   state_o;

  alu_operand_loader #(.N(N), .DB_CYCLES(DB)) dut (
    .clk(clk), .rst_n(rst_n), .sw(sw), .sw_mode(sw_mode),
    .btn_next(btn_next), .btn_clr(btn_clr),
    .in1(in1), .in2(in2), .mode(mode), .valid(valid), .state_o(state_o)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_chk = 0;
  int n_fail = 0;

  typedef struct { int st; int a; int b; int op; int cyc; } exp_t;
  exp_t q[$];

  // reference model: which step we are on and the three held values
  int m_st = 0, m_a = 0, m_b = 0, m_op = 0;

  task automatic chk(input string name, input int act, input int req);
    n_chk++;
    if (act != req) begin
      n_fail++;
      $display("FAIL %s: got %0d, required %0d (cycle %0d)", name, act, req, cyc);
    end
  endtask

  task automatic compare_model(input string tag);
    chk({tag, "_state"}, int'(state_o), m_st);
    chk({tag, "_in1"},   int'(in1),     m_a);
    chk({tag, "_in2"},   int'(in2),     m_b);
    chk({tag, "_mode"},  int'(mode),    m_op);
    chk({tag, "_valid"}, int'(valid),   (m_st == 3) ? 1 : 0);
  endtask

  // monitor: every observed output change must match the oldest expectation, on time
  initial begin
    logic [14:0] prev, cur;
    exp_t e;
    prev = '0;
    forever begin
      @(negedge clk);
      cur = {state_o, in1, in2, mode, valid};
      if (!rst_n)
        prev = cur;
      else if (cur !== prev) begin
        prev = cur;
        if (q.size() == 0) begin
          n_chk++;
          n_fail++;
          $display("FAIL unexpected_change: got state=%0d in1=%0d in2=%0d mode=%0d, required no change (cycle %0d)",
                   state_o, in1, in2, mode, cyc);
        end else begin
          e = q.pop_front();
          chk("sb_state",   int'(state_o), e.st);
          chk("sb_in1",     int'(in1),     e.a);
          chk("sb_in2",     int'(in2),     e.b);
          chk("sb_mode",    int'(mode),    e.op);
          chk("sb_valid",   int'(valid),   (e.st == 3) ? 1 : 0);
          chk("sb_latency", cyc,           e.cyc);
        end
      end
    end
  end

  task automatic wait_drain();
    int k = 0;
    while (q.size() != 0 && k < 40) begin
      @(negedge clk);
      k++;
    end
    if (q.size() != 0) begin
      n_chk++;
      n_fail++;
      $display("FAIL drain_timeout: got %0d pending, required 0 (cycle %0d)", q.size(), cyc);
      q.delete();
    end
  endtask

  // Expected effect of one accepted press, computed from the step rules.
  task automatic push_expect(input bit nxt, input bit clr);
    exp_t e;
    e.st = m_st; e.a = m_a; e.b = m_b; e.op = m_op;
    if (clr) begin
      e.st = 0; e.a = 0; e.b = 0; e.op = 0;
    end else if (nxt) begin
      case (m_st)
        0: e.a  = int'(sw);
        1: e.b  = int'(sw);
        2: e.op = int'(sw_mode);
        default: ;
      endcase
      e.st = (m_st + 1) % 4;
    end
    e.cyc = cyc + LAT;
    if (e.st != m_st || e.a != m_a || e.b != m_b || e.op != m_op)
      q.push_back(e);
    m_st = e.st; m_a = e.a; m_b = e.b; m_op = e.op;
  endtask

  // swv/modv < 0 means random
  task automatic press(input bit nxt, input bit clr, input int hold, input int swv, input int modv);
    @(negedge clk);
    sw      = (swv  < 0) ? N'($urandom) : N'(swv);
    sw_mode = (modv < 0) ? 4'($urandom) : 4'(modv);
    push_expect(nxt, clr);
    btn_next = nxt;
    btn_clr  = clr;
    wait_drain();
    repeat (hold) @(negedge clk);
    btn_next = 1'b0;
    btn_clr  = 1'b0;
    sw       = N'($urandom);
    sw_mode  = 4'($urandom);
    repeat (DB + 6) @(negedge clk);
  endtask

  task automatic glitch(input int len, input bit on_clr);
    @(negedge clk);
    sw = N'($urandom);
    sw_mode = 4'($urandom);
    if (on_clr) btn_clr = 1'b1; else btn_next = 1'b1;
    repeat (len) @(negedge clk);
    btn_next = 1'b0;
    btn_clr  = 1'b0;
    repeat (DB + 6) @(negedge clk);
    compare_model("glitch");
  endtask

  // Reset in the middle of a debounce with the button still held.
  task automatic reset_mid();
    @(negedge clk);
    sw = N'($urandom);
    btn_next = 1'b1;
    repeat (3) @(negedge clk);
    rst_n = 1'b0;
    #1;
    q.delete();
    m_st = 0; m_a = 0; m_b = 0; m_op = 0;
    compare_model("rst_mid");
    repeat (2) @(negedge clk);
    sw = N'($urandom);
    push_expect(1'b1, 1'b0);
    rst_n = 1'b1;
    wait_drain();
    repeat (5) @(negedge clk);
    btn_next = 1'b0;
    repeat (DB + 6) @(negedge clk);
    compare_model("rst_held");
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got simulation time limit, required finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int r;
    repeat (3) @(negedge clk);
    compare_model("reset");
    rst_n = 1'b1;
    repeat (2) @(negedge clk);

    // load 5,1,op 5 and hold the last press long
    press(1, 0, 2, 5, -1);
    press(1, 0, 2, 1, -1);
    press(1, 0, 20, -1, 5);
    compare_model("exec");

    glitch(3, 1'b0);
    glitch(2, 1'b1);

    // leaving EXEC keeps operands
    press(1, 0, 1, -1, -1);
    press(1, 0, 1, 4, -1);
    press(1, 0, 1, 5, -1);
    press(1, 0, 1, -1, -1);
    press(1, 0, 1, -1, -1);
    compare_model("exec_exit");

    // coincident clr+next in LOAD_OP
    press(1, 0, 1, -1, -1);
    press(1, 0, 1, -1, -1);
    press(1, 1, 3, -1, -1);
    compare_model("clr_next");

    press(1, 0, 1, -1, -1);
    reset_mid();

    for (int i = 0; i < 30; i++) begin
      r = $urandom_range(0, 99);
      if (r < 65)      press(1, 0, $urandom_range(0, 25), -1, -1);
      else if (r < 80) press(0, 1, $urandom_range(0, 10), -1, -1);
      else if (r < 90) press(1, 1, $urandom_range(0, 5), -1, -1);
      else             glitch($urandom_range(1, DB - 1), r[0]);
    end
    compare_model("final");

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/alu_operand_loader.md
ALU_OPERAND_LOADER -- requirements
Module: alu_operand_loader

Interface
REQ-001 SHALL have parameter N, default 4, operand width matching the downstream ALU.
REQ-002 SHALL have parameter DB_CYCLES, default 500000, debounce stability count in clock cycles; the bench overrides it to 4.
REQ-003 SHALL have port clk  input  1  single system clock; all state changes on rising edge.
REQ-004 SHALL have port rst_n  input  1  reset, asynchronous, active-low.
REQ-005 SHALL have port sw  input  N  raw data switches, operand source.
REQ-006 SHALL have port sw_mode  input  4  raw switches, ALU operation code source.
REQ-007 SHALL have port btn_next  input  1  raw push button, active-high, advances the sequence.
REQ-008 SHALL have port btn_clr  input  1  raw push button, active-high, aborts to start.
REQ-009 SHALL have port in1  output  N  registered operand A to the ALU.
REQ-010 SHALL have port in2  output  N  registered operand B to the ALU.
REQ-011 SHALL have port mode  output  4  registered operation code to the ALU.
REQ-012 SHALL have port valid  output  1  high while in1/in2/mode form a complete operation.
REQ-013 SHALL have port state_o  output  2  current FSM state encoding for status LEDs.

Function
REQ-014 SHALL implement a four-state FSM: LOAD_A=0, LOAD_B=1, LOAD_OP=2, EXEC=3.
REQ-015 On an accepted next-press, the FSM SHALL: in LOAD_A capture sw into in1 and go to LOAD_B; in LOAD_B capture sw into in2 and go to LOAD_OP; in LOAD_OP capture sw_mode into mode and go to EXEC; in EXEC go to LOAD_A.
REQ-016 valid SHALL be 1 exactly while state is EXEC and 0 in every other state.
REQ-017 in1, in2 and mode SHALL hold their values between captures; leaving EXEC SHALL NOT clear them.
REQ-018 An accepted clr-press in any state SHALL clear in1, in2 and mode to 0 and move to LOAD_A.
REQ-019 A clr-press and a next-press accepted in the same cycle SHALL act as clr only.
REQ-020 Each raw button SHALL pass through a 2-flop synchronizer.
REQ-021 The debounced level SHALL toggle only after the synchronized level has differed from it for DB_CYCLES consecutive cycles. Any cycle of agreement SHALL restart the count.
REQ-022 A press SHALL be a single-cycle pulse generated on each 0->1 transition of the debounced level. A 1->0 transition SHALL generate no pulse.
REQ-023 Holding a button high SHALL yield exactly one press, regardless of hold length.
REQ-024 Latency from the first clock edge sampling a stable raw high to the FSM state/output update SHALL be DB_CYCLES+3 edges.
REQ-025 A glitch shorter than DB_CYCLES synchronized cycles SHALL produce no press and no state change.
REQ-026 Switch inputs SHALL be sampled directly, without debounce, on the capture edge.

Reset
REQ-027 rst_n low SHALL immediately force: state LOAD_A, in1=0, in2=0, mode=0, valid=0, state_o=0, synchronizer flops 0, debounce counters 0, debounced levels 0.
REQ-028 Reset asserted mid-debounce SHALL discard the pending count.
REQ-029 A button held high across reset release SHALL be treated as a new press after DB_CYCLES+3 edges.

Structure
REQ-030 Package alu_pkg SHALL hold the loader_state_t enum (LOAD_A..EXEC, 2 bits) and the constant MODE_W=4.
REQ-031 Synchronizer, debounce counter and rising-edge pulse SHALL live in sub-module btn_debounce, instantiated once per button.
REQ-032 The debounce counter width SHALL be $clog2(DB_CYCLES+1).

Verification (N=4, DB_CYCLES=4)
REQ-033 Reset, then three next-presses with sw=5,1 and sw_mode=5 -> in1=5, in2=1, mode=5, valid=1, state_o=3.
REQ-034 btn_next rises at edge t and is held -> state changes at edge t+7, with no further change while held 20 cycles.
REQ-035 btn_next pulsed high for 3 cycles -> no state change; in1/in2/mode unchanged.
REQ-036 In EXEC with in1=4, in2=5, apply next-press -> state LOAD_A, valid=0, in1=4, in2=5 retained.
REQ-037 In LOAD_OP, btn_next and btn_clr rise on the same edge -> state LOAD_A, in1=in2=mode=0.
REQ-038 rst_n pulsed low mid-debounce in LOAD_B -> all outputs 0 immediately; btn held -> one press after release, capturing sw into in1.
